// File: rtl/mac_sequencer_if.sv
// mac_sequencer_if: command and datapath-control bundle for the MAC-burst sequencer.
//   master : instruction decoder / datapath side. It drives the command and abort,
//            and receives the buffer, array and accumulator controls.
//   slave  : the sequencer itself.
// Signals:
//   cmd_valid/cmd_ready           command handshake
//   cmd_inp_base, cmd_wt_base     first input / weight buffer address
//   cmd_len                       number of input vectors (0 allowed)
//   cmd_out_addr                  output buffer destination
//   abort                         cancel the burst in flight
//   wt_rd_en/wt_buf_addr          weight buffer read strobe and address
//   inp_rd_en/inp_buf_addr        input buffer read strobe and address
//   array_en                      systolic array advance enable
//   acc_clear                     accumulator clear pulse
//   acc_result_to_op_buf          accumulator commit pulse
//   acc_to_op_buf_addr            commit address
//   busy, done                    status
interface mac_sequencer_if #(
    parameter int unsigned ADDR_W  = 15,
    parameter int unsigned OBUF_AW = 4,
    parameter int unsigned LEN_W   = 8
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [ADDR_W-1:0]   cmd_inp_base;
    logic [ADDR_W-1:0]   cmd_wt_base;
    logic [LEN_W-1:0]    cmd_len;
    logic [OBUF_AW-1:0]  cmd_out_addr;
    logic                abort;
    logic                wt_rd_en;
    logic [ADDR_W-1:0]   wt_buf_addr;
    logic                inp_rd_en;
    logic [ADDR_W-1:0]   inp_buf_addr;
    logic                array_en;
    logic                acc_clear;
    logic                acc_result_to_op_buf;
    logic [OBUF_AW-1:0]  acc_to_op_buf_addr;
    logic                busy;
    logic                done;

    modport master (
        output cmd_valid, cmd_inp_base, cmd_wt_base, cmd_len, cmd_out_addr, abort,
        input  cmd_ready, wt_rd_en, wt_buf_addr, inp_rd_en, inp_buf_addr, array_en,
               acc_clear, acc_result_to_op_buf, acc_to_op_buf_addr, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_inp_base, cmd_wt_base, cmd_len, cmd_out_addr, abort,
        output cmd_ready, wt_rd_en, wt_buf_addr, inp_rd_en, inp_buf_addr, array_en,
               acc_clear, acc_result_to_op_buf, acc_to_op_buf_addr, busy, done
    );
endinterface

// File: rtl/mac_sequencer.sv
// mac_sequencer: turns one MAC-burst command into per-cycle control for the
// weight buffer, input buffer, systolic array and accumulator commit path.
// Burst: LOAD_WT (WT_ROWS cycles) -> MAC (len cycles, skipped if len=0)
//        -> DRAIN (DRAIN cycles) -> STORE (1 cycle) -> IDLE.
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   seq_if  slave side of mac_sequencer_if (command in, controls/status out)
// Every output is a register loaded from the next-state decode, so each output
// is valid in exactly the cycle its state occupies.
module mac_sequencer #(
    parameter int unsigned ADDR_W  = 15,
    parameter int unsigned OBUF_AW = 4,
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned WT_ROWS = 4,
    parameter int unsigned DRAIN   = 8
) (
    input  logic              clk,
    input  logic              rst,
    mac_sequencer_if.slave    seq_if
);

    // Counter wide enough for the largest phase length of any of the three phases
    localparam int unsigned WT_CW = $clog2(WT_ROWS + 1);
    localparam int unsigned DR_CW = $clog2(DRAIN + 1);
    localparam int unsigned PH_CW = (WT_CW > DR_CW) ? WT_CW : DR_CW;
    localparam int unsigned CNT_W = (LEN_W > PH_CW) ? LEN_W : PH_CW;

    localparam logic [CNT_W-1:0] WT_LAST = CNT_W'(WT_ROWS - 1);
    localparam logic [CNT_W-1:0] DR_LAST = CNT_W'(DRAIN - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD_WT = 3'd1;
    localparam logic [2:0] S_MAC     = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_STORE   = 3'd4;

    // State, phase counter and latched command
    logic [2:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   inp_base_q, inp_base_d;
    logic [ADDR_W-1:0]   wt_base_q, wt_base_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [OBUF_AW-1:0]  out_addr_q, out_addr_d;

    // Registered outputs
    logic                cmd_ready_q, cmd_ready_d;
    logic                busy_q, busy_d;
    logic                wt_rd_en_q, wt_rd_en_d;
    logic [ADDR_W-1:0]   wt_addr_q, wt_addr_d;
    logic                inp_rd_en_q, inp_rd_en_d;
    logic [ADDR_W-1:0]   inp_addr_q, inp_addr_d;
    logic                array_en_q, array_en_d;
    logic                acc_clear_q, acc_clear_d;
    logic                acc_store_q, acc_store_d;
    logic [OBUF_AW-1:0]  obuf_addr_q, obuf_addr_d;
    logic                done_q, done_d;

    // Next-state decode, then the output values for the state being entered
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        inp_base_d  = inp_base_q;
        wt_base_d   = wt_base_q;
        len_d       = len_q;
        out_addr_d  = out_addr_q;

        cmd_ready_d = 1'b0;
        busy_d      = 1'b0;
        wt_rd_en_d  = 1'b0;
        wt_addr_d   = '0;
        inp_rd_en_d = 1'b0;
        inp_addr_d  = '0;
        array_en_d  = 1'b0;
        acc_clear_d = 1'b0;
        acc_store_d = 1'b0;
        obuf_addr_d = '0;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (seq_if.cmd_valid && cmd_ready_q) begin
                    inp_base_d = seq_if.cmd_inp_base;
                    wt_base_d  = seq_if.cmd_wt_base;
                    len_d      = seq_if.cmd_len;
                    out_addr_d = seq_if.cmd_out_addr;
                    state_d    = S_LOAD_WT;
                    cnt_d      = '0;
                end
            end
            S_LOAD_WT: begin
                if (cnt_q == WT_LAST) begin
                    cnt_d   = '0;
                    state_d = (len_q != '0) ? S_MAC : S_DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_MAC: begin
                // MAC is only entered with len_q >= 1, so len_q-1 cannot underflow
                if (cnt_q == (CNT_W'(len_q) - CNT_W'(1))) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == DR_LAST) begin
                    cnt_d   = '0;
                    state_d = S_STORE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STORE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // Abort cancels any burst in flight; a STORE already on the outputs stays committed
        if (seq_if.abort && (state_q != S_IDLE)) begin
            cnt_d   = '0;
            state_d = S_IDLE;
        end

        // Moore outputs for the state entered at the next edge
        case (state_d)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
            end
            S_LOAD_WT: begin
                busy_d      = 1'b1;
                wt_rd_en_d  = 1'b1;
                wt_addr_d   = wt_base_d + ADDR_W'(cnt_d);
                acc_clear_d = (cnt_d == '0);
            end
            S_MAC: begin
                busy_d      = 1'b1;
                inp_rd_en_d = 1'b1;
                inp_addr_d  = inp_base_d + ADDR_W'(cnt_d);
                array_en_d  = 1'b1;
            end
            S_DRAIN: begin
                busy_d     = 1'b1;
                array_en_d = 1'b1;
            end
            S_STORE: begin
                busy_d      = 1'b1;
                acc_store_d = 1'b1;
                obuf_addr_d = out_addr_d;
                done_d      = 1'b1;
            end
            default: begin
                cmd_ready_d = 1'b0;
            end
        endcase
    end

    // State, command and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            inp_base_q  <= '0;
            wt_base_q   <= '0;
            len_q       <= '0;
            out_addr_q  <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            wt_rd_en_q  <= 1'b0;
            wt_addr_q   <= '0;
            inp_rd_en_q <= 1'b0;
            inp_addr_q  <= '0;
            array_en_q  <= 1'b0;
            acc_clear_q <= 1'b0;
            acc_store_q <= 1'b0;
            obuf_addr_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            inp_base_q  <= inp_base_d;
            wt_base_q   <= wt_base_d;
            len_q       <= len_d;
            out_addr_q  <= out_addr_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            wt_rd_en_q  <= wt_rd_en_d;
            wt_addr_q   <= wt_addr_d;
            inp_rd_en_q <= inp_rd_en_d;
            inp_addr_q  <= inp_addr_d;
            array_en_q  <= array_en_d;
            acc_clear_q <= acc_clear_d;
            acc_store_q <= acc_store_d;
            obuf_addr_q <= obuf_addr_d;
            done_q      <= done_d;
        end
    end

    assign seq_if.cmd_ready            = cmd_ready_q;
    assign seq_if.busy                 = busy_q;
    assign seq_if.wt_rd_en             = wt_rd_en_q;
    assign seq_if.wt_buf_addr          = wt_addr_q;
    assign seq_if.inp_rd_en            = inp_rd_en_q;
    assign seq_if.inp_buf_addr         = inp_addr_q;
    assign seq_if.array_en             = array_en_q;
    assign seq_if.acc_clear            = acc_clear_q;
    assign seq_if.acc_result_to_op_buf = acc_store_q;
    assign seq_if.acc_to_op_buf_addr   = obuf_addr_q;
    assign seq_if.done                 = done_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: table-driven bursts plus hand-written corner sequences.
// A scoreboard queue holds the expected output vector for every future cycle of
// an accepted burst; each cycle pops one entry (or expects the idle vector).
module tb_mac_sequencer;

    localparam int unsigned ADDR_W  = 15;
    localparam int unsigned OBUF_AW = 4;
    localparam int unsigned LEN_W   = 8;
    localparam int unsigned WT_ROWS = 4;
    localparam int unsigned DRAIN   = 8;

    typedef struct packed {
        logic [14:0] wt;
        logic [14:0] inp;
        logic [7:0]  len;
        logic [3:0]  oa;
    } cmd_t;

    typedef struct packed {
        logic        cmd_ready;
        logic        busy;
        logic        wt_rd_en;
        logic [14:0] wt_addr;
        logic        inp_rd_en;
        logic [14:0] inp_addr;
        logic        array_en;
        logic        acc_clear;
        logic        acc_store;
        logic [3:0]  obuf_addr;
        logic        done;
    } outv_t;

    typedef struct {
        cmd_t c;
        int   abort_at;
        int   exp_done;
        int   exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mac_sequencer_if #(.ADDR_W(ADDR_W), .OBUF_AW(OBUF_AW), .LEN_W(LEN_W)) bus ();

    mac_sequencer #(
        .ADDR_W (ADDR_W),
        .OBUF_AW(OBUF_AW),
        .LEN_W  (LEN_W),
        .WT_ROWS(WT_ROWS),
        .DRAIN  (DRAIN)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .seq_if(bus)
    );

    outv_t q[$];
    int    done_cyc[$];
    bit    cur_busy = 1'b0;
    int    cyc = 0;
    int    errors = 0;
    int    checks = 0;
    vec_t  vecs[7];

    function automatic outv_t idle_v();
        outv_t o = '0;
        o.cmd_ready = 1'b1;
        return o;
    endfunction

    function automatic outv_t sample();
        outv_t o;
        o.cmd_ready = bus.cmd_ready;
        o.busy      = bus.busy;
        o.wt_rd_en  = bus.wt_rd_en;
        o.wt_addr   = bus.wt_buf_addr;
        o.inp_rd_en = bus.inp_rd_en;
        o.inp_addr  = bus.inp_buf_addr;
        o.array_en  = bus.array_en;
        o.acc_clear = bus.acc_clear;
        o.acc_store = bus.acc_result_to_op_buf;
        o.obuf_addr = bus.acc_to_op_buf_addr;
        o.done      = bus.done;
        return o;
    endfunction

    // Expected per-cycle trace of one burst, straight from the phase timing
    task automatic push_burst(input cmd_t c);
        outv_t o;
        for (int i = 0; i < int'(WT_ROWS); i++) begin
            o = '0; o.busy = 1'b1; o.wt_rd_en = 1'b1;
            o.wt_addr = c.wt + 15'(i); o.acc_clear = (i == 0);
            q.push_back(o);
        end
        for (int i = 0; i < int'(c.len); i++) begin
            o = '0; o.busy = 1'b1; o.inp_rd_en = 1'b1;
            o.inp_addr = c.inp + 15'(i); o.array_en = 1'b1;
            q.push_back(o);
        end
        for (int i = 0; i < int'(DRAIN); i++) begin
            o = '0; o.busy = 1'b1; o.array_en = 1'b1;
            q.push_back(o);
        end
        o = '0; o.busy = 1'b1; o.acc_store = 1'b1; o.obuf_addr = c.oa; o.done = 1'b1;
        q.push_back(o);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outputs();
        outv_t exp_o, act_o;
        if (q.size() > 0) begin
            exp_o = q.pop_front();
            cur_busy = 1'b1;
        end else begin
            exp_o = idle_v();
            cur_busy = 1'b0;
        end
        act_o = sample();
        checks++;
        if (act_o !== exp_o) begin
            errors++;
            $display("FAIL outputs cycle %0d: got rdy=%b busy=%b wt=%b/%h inp=%b/%h arr=%b clr=%b st=%b/%h done=%b expected rdy=%b busy=%b wt=%b/%h inp=%b/%h arr=%b clr=%b st=%b/%h done=%b",
                     cyc, act_o.cmd_ready, act_o.busy, act_o.wt_rd_en, act_o.wt_addr,
                     act_o.inp_rd_en, act_o.inp_addr, act_o.array_en, act_o.acc_clear,
                     act_o.acc_store, act_o.obuf_addr, act_o.done,
                     exp_o.cmd_ready, exp_o.busy, exp_o.wt_rd_en, exp_o.wt_addr,
                     exp_o.inp_rd_en, exp_o.inp_addr, exp_o.array_en, exp_o.acc_clear,
                     exp_o.acc_store, exp_o.obuf_addr, exp_o.done);
        end
        if (act_o.done === 1'b1) done_cyc.push_back(cyc);
    endtask

    // Drive inputs for the current cycle, update the model at the edge, check outputs
    task automatic cycle(input logic v, input logic ab, input logic r, input cmd_t c);
        bus.cmd_valid    = v;
        bus.abort        = ab;
        rst              = r;
        bus.cmd_wt_base  = c.wt;
        bus.cmd_inp_base = c.inp;
        bus.cmd_len      = c.len;
        bus.cmd_out_addr = c.oa;
        @(posedge clk);
        cyc++;
        if (r) q.delete();
        else if (ab && cur_busy) q.delete();
        else if (v && !cur_busy) push_burst(c);
        #1;
        check_outputs();
    endtask

    initial begin
        cmd_t zc;
        cmd_t ca;
        cmd_t cb;
        int   base;
        int   run_len;

        zc = '0;
        vecs[0] = '{c: '{wt: 15'h0010, inp: 15'h0100, len: 8'd3,   oa: 4'd5},  abort_at: -1, exp_done: 1, exp_lat: 16};
        vecs[1] = '{c: '{wt: 15'h0020, inp: 15'h0200, len: 8'd0,   oa: 4'd7},  abort_at: -1, exp_done: 1, exp_lat: 13};
        vecs[2] = '{c: '{wt: 15'h7FFD, inp: 15'h7FFE, len: 8'd4,   oa: 4'd9},  abort_at: -1, exp_done: 1, exp_lat: 17};
        vecs[3] = '{c: '{wt: 15'h0040, inp: 15'h0400, len: 8'd3,   oa: 4'd2},  abort_at: 6,  exp_done: 0, exp_lat: 0};
        vecs[4] = '{c: '{wt: 15'h1234, inp: 15'h7F80, len: 8'd255, oa: 4'd15}, abort_at: -1, exp_done: 1, exp_lat: 268};
        vecs[5] = '{c: '{wt: 15'h0050, inp: 15'h0500, len: 8'd1,   oa: 4'd11}, abort_at: 14, exp_done: 1, exp_lat: 14};
        vecs[6] = '{c: '{wt: 15'h0060, inp: 15'h0600, len: 8'd2,   oa: 4'd1},  abort_at: 2,  exp_done: 0, exp_lat: 0};

        // Reset: outputs idle, cmd_ready high
        cycle(1'b0, 1'b0, 1'b1, zc);
        cycle(1'b1, 1'b1, 1'b1, vecs[0].c);
        chk_int("reset_cmd_ready", int'(bus.cmd_ready), 1);
        chk_int("reset_busy", int'(bus.busy), 0);
        cycle(1'b0, 1'b0, 1'b0, zc);

        // Table-driven bursts
        foreach (vecs[n]) begin
            done_cyc.delete();
            base = cyc;
            cycle(1'b1, 1'b0, 1'b0, vecs[n].c);
            run_len = int'(WT_ROWS) + int'(vecs[n].c.len) + int'(DRAIN) + 3;
            for (int k = 1; k <= run_len; k++)
                cycle(1'b0, (k == vecs[n].abort_at), 1'b0, zc);
            chk_int($sformatf("vec%0d_done_count", n), done_cyc.size(), vecs[n].exp_done);
            if (vecs[n].exp_done > 0 && done_cyc.size() > 0)
                chk_int($sformatf("vec%0d_latency", n), done_cyc[0] - base, vecs[n].exp_lat);
        end

        // Abort in the second MAC cycle, new command accepted as cmd_ready rises
        ca = '{wt: 15'h0070, inp: 15'h0700, len: 8'd3, oa: 4'd4};
        cb = '{wt: 15'h0080, inp: 15'h0800, len: 8'd0, oa: 4'd3};
        done_cyc.delete();
        base = cyc;
        cycle(1'b1, 1'b0, 1'b0, ca);
        for (int k = 1; k <= 5; k++) cycle(1'b0, 1'b0, 1'b0, zc);
        cycle(1'b0, 1'b1, 1'b0, zc);
        chk_int("abort_idle_ready", int'(bus.cmd_ready), 1);
        cycle(1'b1, 1'b0, 1'b0, cb);
        for (int k = 0; k < 16; k++) cycle(1'b0, 1'b0, 1'b0, zc);
        chk_int("abort_reaccept_done_count", done_cyc.size(), 1);
        if (done_cyc.size() > 0) chk_int("abort_reaccept_done_cycle", done_cyc[0] - base, 7 + 13);

        // Reset during DRAIN with cmd_valid high: only accepted once rst drops
        done_cyc.delete();
        base = cyc;
        cycle(1'b1, 1'b0, 1'b0, cb);
        for (int k = 1; k <= 6; k++) cycle(1'b0, 1'b0, 1'b0, zc);
        cycle(1'b1, 1'b0, 1'b1, ca);
        chk_int("rst_mid_busy", int'(bus.busy), 0);
        cycle(1'b1, 1'b0, 1'b0, cb);
        for (int k = 0; k < 15; k++) cycle(1'b0, 1'b0, 1'b0, zc);
        chk_int("rst_mid_done_count", done_cyc.size(), 1);
        if (done_cyc.size() > 0) chk_int("rst_mid_done_cycle", done_cyc[0] - base, 8 + 13);

        // cmd_valid held high, len=1: back-to-back period WT_ROWS+len+DRAIN+2 = 15
        ca = '{wt: 15'h0090, inp: 15'h0900, len: 8'd1, oa: 4'd6};
        done_cyc.delete();
        base = cyc;
        for (int k = 0; k <= 44; k++) cycle(1'b1, 1'b0, 1'b0, ca);
        for (int k = 0; k < 16; k++) cycle(1'b0, 1'b0, 1'b0, zc);
        chk_int("b2b_done_count", done_cyc.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < done_cyc.size())
                chk_int($sformatf("b2b_done%0d_cycle", i), done_cyc[i] - base, 14 + 15 * i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
